// File: rtl/chess_pkg.sv
// Shared piece codes, FSM states and the decoded-character record used by the FEN streamer.
package chess_pkg;

    localparam int unsigned PIECE_W    = 4;
    localparam int unsigned COLOUR_BIT = 3;
    localparam int unsigned SQ_COUNT   = 64;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } piece_t;

    typedef enum logic [2:0] {
        StIdle,
        StBoard,
        StExpand,
        StSide,
        StSkip
    } fen_state_e;

    typedef struct packed {
        logic               is_piece;
        logic [PIECE_W-1:0] piece;
        logic               is_digit;
        logic [3:0]         run_len;
        logic               is_slash;
        logic               is_space;
        logic               is_side;
        logic               side_white;
    } fen_char_t;

endpackage

// File: rtl/fen_char_decode.sv
// Combinational classifier for one FEN character: piece, empty-run digit, separator or side.
module fen_char_decode
    import chess_pkg::*;
#(
    parameter int unsigned CHAR_W = 8
) (
    input  logic [CHAR_W-1:0] ch,
    output fen_char_t         dec
);

    logic [7:0] c;
    logic [7:0] folded;
    piece_t     ptype;

    assign c      = ch[7:0];
    assign folded = c | 8'h20;

    always_comb begin
        dec   = '0;
        ptype = EMPTY;
        // Folding bit 5 lets one case arm match both colours of a piece letter.
        case (folded)
            "p":     ptype = PAWN;
            "n":     ptype = KNIGHT;
            "b":     ptype = BISHOP;
            "r":     ptype = ROOK;
            "q":     ptype = QUEEN;
            "k":     ptype = KING;
            default: ptype = EMPTY;
        endcase
        dec.is_piece   = (ptype != EMPTY);
        dec.piece      = dec.is_piece ? {c[5], ptype} : '0;
        dec.is_digit   = (c >= "1") && (c <= "8");
        dec.run_len    = c[3:0];
        dec.is_slash   = (c == "/");
        dec.is_space   = (c == " ");
        dec.is_side    = (c == "w") || (c == "b");
        dec.side_white = (c == "w");
    end

endmodule

// File: rtl/fen_board_streamer.sv
// Parses the board and side-to-move fields of an ASCII FEN stream into a 64-beat square stream.
module fen_board_streamer
    import chess_pkg::*;
#(
    parameter int unsigned CHAR_W  = 8,
    parameter int unsigned PIECE_W = chess_pkg::PIECE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_fen_valid,
    input  logic [CHAR_W-1:0]  in_fen_data,
    input  logic               in_fen_sop,
    output logic               in_fen_ready,
    output logic               out_pos_valid,
    output logic [PIECE_W-1:0] out_pos_data,
    output logic               out_pos_sop,
    output logic               out_white_to_move,
    output logic               out_done,
    output logic               out_err
);

    localparam logic [6:0] SQ_END = 7'(SQ_COUNT);

    fen_state_e state;
    logic [6:0] sq;
    logic [3:0] run;
    logic       rank_done;

    fen_char_t  dec;
    logic       accept;
    logic [6:0] sq_b;
    logic       rank_b;
    logic [3:0] file_end;
    logic [3:0] run_load;
    logic       place_ok;

    fen_char_decode #(
        .CHAR_W(CHAR_W)
    ) u_decode (
        .ch (in_fen_data),
        .dec(dec)
    );

    // A sop char is parsed as if the board were empty, whatever state we were in.
    assign accept   = in_fen_valid & in_fen_ready;
    assign sq_b     = in_fen_sop ? '0 : sq;
    assign rank_b   = in_fen_sop ? 1'b0 : rank_done;
    assign file_end = {1'b0, sq_b[2:0]} + dec.run_len;
    assign run_load = dec.run_len - 4'd1;
    assign place_ok = (sq_b < SQ_END) && !rank_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= StIdle;
            sq                <= '0;
            run               <= '0;
            rank_done         <= 1'b0;
            in_fen_ready      <= 1'b0;
            out_pos_valid     <= 1'b0;
            out_pos_data      <= '0;
            out_pos_sop       <= 1'b0;
            out_done          <= 1'b0;
            out_err           <= 1'b0;
            out_white_to_move <= 1'b1;
        end else begin
            out_pos_valid <= 1'b0;
            out_pos_data  <= '0;
            out_pos_sop   <= 1'b0;
            out_done      <= 1'b0;
            out_err       <= 1'b0;
            in_fen_ready  <= 1'b1;
            if (state == StExpand) begin
                out_pos_valid <= 1'b1;
                sq            <= sq + 7'd1;
                run           <= run - 4'd1;
                if (run == 4'd1) begin
                    state <= StBoard;
                end else begin
                    in_fen_ready <= 1'b0;
                end
            end else if (accept) begin
                if (in_fen_sop || state == StBoard) begin
                    state     <= StBoard;
                    sq        <= sq_b;
                    rank_done <= rank_b;
                    if (dec.is_piece && place_ok) begin
                        out_pos_valid <= 1'b1;
                        out_pos_data  <= PIECE_W'(dec.piece);
                        out_pos_sop   <= (sq_b == '0);
                        sq            <= sq_b + 7'd1;
                        rank_done     <= (sq_b[2:0] == 3'd7);
                    end else if (dec.is_digit && place_ok && file_end <= 4'd8) begin
                        out_pos_valid <= 1'b1;
                        out_pos_sop   <= (sq_b == '0);
                        sq            <= sq_b + 7'd1;
                        rank_done     <= (file_end == 4'd8);
                        if (dec.run_len > 4'd1) begin
                            run          <= run_load;
                            state        <= StExpand;
                            in_fen_ready <= 1'b0;
                        end
                    end else if (dec.is_slash && sq_b[2:0] == 3'd0 && sq_b != '0
                                 && sq_b < SQ_END) begin
                        rank_done <= 1'b0;
                    end else if (dec.is_space && sq_b == SQ_END) begin
                        state <= StSide;
                    end else begin
                        out_err <= 1'b1;
                        state   <= StSkip;
                    end
                end else if (state == StSide) begin
                    if (dec.is_side) begin
                        out_white_to_move <= dec.side_white;
                        out_done          <= 1'b1;
                    end else begin
                        out_err <= 1'b1;
                    end
                    state <= StSkip;
                end
            end
        end
    end

endmodule

// File: tb/tb_fen_board_streamer.sv
// Randomized and directed bench for fen_board_streamer against a char-level FEN reference model.
module tb_fen_board_streamer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_fen_valid = 1'b0;
    logic [7:0] in_fen_data = 8'h00;
    logic       in_fen_sop = 1'b0;
    logic       in_fen_ready;
    logic       out_pos_valid;
    logic [3:0] out_pos_data;
    logic       out_pos_sop;
    logic       out_white_to_move;
    logic       out_done;
    logic       out_err;

    fen_board_streamer #(
        .CHAR_W (8),
        .PIECE_W(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_fen_valid     (in_fen_valid),
        .in_fen_data      (in_fen_data),
        .in_fen_sop       (in_fen_sop),
        .in_fen_ready     (in_fen_ready),
        .out_pos_valid    (out_pos_valid),
        .out_pos_data     (out_pos_data),
        .out_pos_sop      (out_pos_sop),
        .out_white_to_move(out_white_to_move),
        .out_done         (out_done),
        .out_err          (out_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: everything seen on the output side, sampled mid-cycle.
    int got_data[$];
    bit got_sop[$];
    int got_cyc[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int rdy_low = 0;
    bit count_rdy = 1'b0;
    always @(negedge clk) begin
        if (out_pos_valid) begin
            got_data.push_back(int'(out_pos_data));
            got_sop.push_back(out_pos_sop);
            got_cyc.push_back(cyc);
        end
        if (out_done) done_cnt++;
        if (out_err) err_cnt++;
        if (count_rdy && !in_fen_ready) rdy_low++;
    end

    // Reference model: expected beats and result of parsing whole FEN strings.
    int exp_data[$];
    bit exp_sop[$];
    int exp_done;
    int exp_err;
    bit exp_white = 1'b1;
    int acc_cyc_first;

    function automatic int piece_code(input byte c);
        string up = "PNBRQK";
        for (int i = 0; i < 6; i++) begin
            if (c == up[i]) return i + 1;
            if (c == (up[i] | 8'h20)) return i + 9;
        end
        return -1;
    endfunction

    task automatic clear_exp();
        exp_data.delete();
        exp_sop.delete();
        exp_done = 0;
        exp_err = 0;
    endtask

    task automatic model_fen(input string s);
        int sq = 0;
        int mode = 0;  // 0 board, 1 side, 2 finished
        bit need_slash = 0;
        bit first = 1;
        for (int i = 0; i < s.len(); i++) begin
            byte c = s[i];
            bit fail = 0;
            if (mode == 0) begin
                if (piece_code(c) >= 0 || (c >= "1" && c <= "8")) begin
                    int n = (piece_code(c) >= 0) ? 1 : int'(c - "0");
                    if (sq >= 64 || need_slash || (sq % 8) + n > 8) fail = 1;
                    else begin
                        for (int k = 0; k < n; k++) begin
                            exp_data.push_back(k == 0 && piece_code(c) >= 0 ? piece_code(c) : 0);
                            exp_sop.push_back(first);
                            first = 0;
                        end
                        sq += n;
                        need_slash = (sq % 8 == 0);
                    end
                end else if (c == "/") begin
                    if (sq % 8 == 0 && sq != 0 && sq < 64) need_slash = 0;
                    else fail = 1;
                end else if (c == " ") begin
                    if (sq == 64) mode = 1;
                    else fail = 1;
                end else fail = 1;
            end else if (mode == 1) begin
                if (c == "w" || c == "b") begin
                    exp_white = (c == "w");
                    exp_done++;
                    mode = 2;
                end else fail = 1;
            end
            if (fail) begin
                exp_err++;
                mode = 2;
            end
        end
    endtask

    task automatic send_fen(input string s);
        for (int i = 0; i < s.len(); i++) begin
            int waited = 0;
            @(negedge clk);
            in_fen_valid = 1'b1;
            in_fen_data = s[i];
            in_fen_sop = (i == 0);
            while (!in_fen_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 50) begin
                total++;
                bad++;
                $display("FAIL ready_timeout char=%0d ready=%b required=1", i, in_fen_ready);
            end
            if (i == 0) acc_cyc_first = cyc;
            @(posedge clk);
        end
        @(negedge clk);
        in_fen_valid = 1'b0;
        in_fen_sop = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({in_fen_ready, out_pos_valid, out_pos_data, out_pos_sop, out_done, out_err,
             out_white_to_move} !== 10'b0_0_0000_0_0_0_1) begin
            bad++;
            $display("FAIL reset_outputs got=%b required=%b", {in_fen_ready, out_pos_valid,
                     out_pos_data, out_pos_sop, out_done, out_err, out_white_to_move},
                     10'b0_0_0000_0_0_0_1);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (in_fen_ready !== 1'b1 || out_pos_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset ready=%b valid=%b required ready=1 valid=0",
                     in_fen_ready, out_pos_valid);
        end
    endtask

    task automatic test_start_position();
        string s = "rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w";
        int b0 = got_data.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int zeros = 0;
        clear_exp();
        model_fen(s);
        send_fen(s);
        total++;
        if (got_data.size() - b0 != 64) begin
            bad++;
            $display("FAIL start_beats got=%0d required=64", got_data.size() - b0);
        end else begin
            for (int k = 0; k < 64; k++) begin
                total++;
                if (got_data[b0+k] !== exp_data[k] || got_sop[b0+k] !== exp_sop[k]) begin
                    bad++;
                    $display("FAIL start_beat%0d got=%h/%b required=%h/%b", k, got_data[b0+k],
                             got_sop[b0+k], exp_data[k], exp_sop[k]);
                end
            end
            for (int k = 16; k < 48; k++) if (got_data[b0+k] == 0) zeros++;
            total++;
            if (got_data[b0] !== 12 || got_sop[b0] !== 1'b1 || got_data[b0+4] !== 14 ||
                got_data[b0+60] !== 6 || zeros != 32) begin
                bad++;
                $display("FAIL start_landmarks b0=%h sop=%b b4=%h b60=%h zeros=%0d required c/1/e/6/32",
                         got_data[b0], got_sop[b0], got_data[b0+4], got_data[b0+60], zeros);
            end
            total++;
            if (got_cyc[b0] != acc_cyc_first + 1) begin
                bad++;
                $display("FAIL start_latency got=%0d required=%0d", got_cyc[b0], acc_cyc_first + 1);
            end
        end
        total++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || out_white_to_move !== 1'b1) begin
            bad++;
            $display("FAIL start_result done=%0d err=%0d white=%b required 1/0/1",
                     done_cnt - d0, err_cnt - e0, out_white_to_move);
        end
    endtask

    task automatic test_empty_board();
        string s = "8/8/8/8/8/8/8/8 b";
        int b0 = got_data.size();
        int d0 = done_cnt;
        int r0 = rdy_low;
        int nz = 0;
        clear_exp();
        model_fen(s);
        count_rdy = 1'b1;
        send_fen(s);
        count_rdy = 1'b0;
        for (int k = b0; k < got_data.size(); k++) if (got_data[k] != 0) nz++;
        total++;
        if (got_data.size() - b0 != 64 || nz != 0) begin
            bad++;
            $display("FAIL empty_beats got=%0d nonzero=%0d required 64/0", got_data.size() - b0, nz);
        end
        total++;
        if (rdy_low - r0 != 56) begin
            bad++;
            $display("FAIL empty_stall got=%0d required=56", rdy_low - r0);
        end
        total++;
        if (done_cnt - d0 != 1 || out_white_to_move !== 1'b0 || exp_white !== 1'b0) begin
            bad++;
            $display("FAIL empty_side done=%0d white=%b required 1/0", done_cnt - d0,
                     out_white_to_move);
        end
    endtask

    task automatic test_bad_boards();
        string cases[3] = '{"9/8/8/8/8/8/8/8 w", "ppppppppp/8/8/8/8/8/8/8 w", "8/8 w"};
        int want_beats[3] = '{0, 8, 16};
        for (int t = 0; t < 3; t++) begin
            int b0 = got_data.size();
            int d0 = done_cnt;
            int e0 = err_cnt;
            clear_exp();
            model_fen(cases[t]);
            send_fen(cases[t]);
            total++;
            if (got_data.size() - b0 != want_beats[t] || exp_data.size() != want_beats[t]) begin
                bad++;
                $display("FAIL bad%0d_beats got=%0d required=%0d", t, got_data.size() - b0,
                         want_beats[t]);
            end
            total++;
            if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
                bad++;
                $display("FAIL bad%0d_flags err=%0d done=%0d required 1/0", t, err_cnt - e0,
                         done_cnt - d0);
            end
        end
    endtask

    task automatic test_sop_restart();
        string part = "rnbqkbnr/pppppppp/4";
        string full = "rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w";
        int b0 = got_data.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        clear_exp();
        model_fen(part);
        model_fen(full);
        send_fen(part);
        send_fen(full);
        total++;
        if (got_data.size() - b0 != 84) begin
            bad++;
            $display("FAIL restart_beats got=%0d required=84", got_data.size() - b0);
        end else begin
            for (int k = 0; k < 84; k++) begin
                total++;
                if (got_data[b0+k] !== exp_data[k] || got_sop[b0+k] !== exp_sop[k]) begin
                    bad++;
                    $display("FAIL restart_beat%0d got=%h/%b required=%h/%b", k, got_data[b0+k],
                             got_sop[b0+k], exp_data[k], exp_sop[k]);
                end
            end
            total++;
            if (got_sop[b0+20] !== 1'b1) begin
                bad++;
                $display("FAIL restart_sop got=%b required=1", got_sop[b0+20]);
            end
        end
        total++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            bad++;
            $display("FAIL restart_flags done=%0d err=%0d required 1/0", done_cnt - d0,
                     err_cnt - e0);
        end
    endtask

    task automatic test_reset_expand();
        string s = "r7/8/8/8/8/8/8/7K b";
        int b0;
        int d0;
        @(negedge clk);
        in_fen_valid = 1'b1;
        in_fen_data = "8";
        in_fen_sop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_fen_valid = 1'b0;
        in_fen_sop = 1'b0;
        @(negedge clk);
        total++;
        if (in_fen_ready !== 1'b0 || out_pos_valid !== 1'b1) begin
            bad++;
            $display("FAIL expand_active ready=%b valid=%b required 0/1", in_fen_ready,
                     out_pos_valid);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({in_fen_ready, out_pos_valid, out_pos_data, out_pos_sop, out_done, out_err,
             out_white_to_move} !== 10'b0_0_0000_0_0_0_1) begin
            bad++;
            $display("FAIL async_reset got=%b required=%b", {in_fen_ready, out_pos_valid,
                     out_pos_data, out_pos_sop, out_done, out_err, out_white_to_move},
                     10'b0_0_0000_0_0_0_1);
        end
        exp_white = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        b0 = got_data.size();
        d0 = done_cnt;
        clear_exp();
        model_fen(s);
        send_fen(s);
        total++;
        if (got_data.size() - b0 != 64 || got_data[b0] !== 12 || got_data[b0+63] !== 6 ||
            done_cnt - d0 != 1 || out_white_to_move !== 1'b0) begin
            bad++;
            $display("FAIL after_reset beats=%0d done=%0d white=%b required 64/1/0",
                     got_data.size() - b0, done_cnt - d0, out_white_to_move);
        end
    endtask

    task automatic test_random();
        string pcs = "pnbrqkPNBRQK";
        for (int it = 0; it < 30; it++) begin
            string s = "";
            int mode = $urandom_range(0, 3);
            int b0 = got_data.size();
            int d0 = done_cnt;
            int e0 = err_cnt;
            int errs = 0;
            for (int r = 0; r < 8; r++) begin
                int run = 0;
                for (int f = 0; f < 8; f++) begin
                    if ($urandom_range(0, 1) == 0) begin
                        run++;
                        if ($urandom_range(0, 3) == 0) begin
                            s = $sformatf("%s%0d", s, run);
                            run = 0;
                        end
                    end else begin
                        if (run > 0) s = $sformatf("%s%0d", s, run);
                        run = 0;
                        s = $sformatf("%s%c", s, pcs[$urandom_range(0, 11)]);
                    end
                end
                if (run > 0) s = $sformatf("%s%0d", s, run);
                if (r < 7) s = {s, "/"};
            end
            s = {s, ($urandom_range(0, 1) != 0) ? " w" : " b"};
            if (mode == 2) s.putc($urandom_range(0, s.len() - 1), 8'($urandom_range(32, 126)));
            if (mode == 3) s = s.substr(0, $urandom_range(0, s.len() - 2));
            clear_exp();
            model_fen(s);
            send_fen(s);
            total++;
            if (got_data.size() - b0 != exp_data.size()) begin
                bad++;
                $display("FAIL rnd%0d_beats got=%0d required=%0d fen=%s", it,
                         got_data.size() - b0, exp_data.size(), s);
            end else begin
                for (int k = 0; k < exp_data.size(); k++)
                    if (got_data[b0+k] !== exp_data[k] || got_sop[b0+k] !== exp_sop[k]) errs++;
                total++;
                if (errs != 0) begin
                    bad++;
                    $display("FAIL rnd%0d_data wrong_beats=%0d required=0 fen=%s", it, errs, s);
                end
            end
            total++;
            if (done_cnt - d0 != exp_done || err_cnt - e0 != exp_err ||
                out_white_to_move !== exp_white) begin
                bad++;
                $display("FAIL rnd%0d_flags done=%0d err=%0d white=%b required %0d/%0d/%b fen=%s",
                         it, done_cnt - d0, err_cnt - e0, out_white_to_move, exp_done, exp_err,
                         exp_white, s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_position();
        test_empty_board();
        test_bad_boards();
        test_sop_restart();
        test_reset_expand();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
